trax_move_decoder: RTL and testbench
====================================

TRAX_MOVE_DECODER -- requirements
Module: trax_move_decoder

Interface
REQ-001 Parameter ROW_DIGITS_MAX, default 4, maximum number of decimal row digits accepted per move.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  ASCII byte from the UART receiver.
REQ-005 rx_valid  input  1  rx_data is valid this cycle; one byte is consumed per asserted cycle.
REQ-006 move_out  output  22  {tile[21:20], col[19:10], row[9:0]}; tile codes: plus=01, slash=10, bslash=11.
REQ-007 move_valid  output  1  one-cycle pulse; move_out holds a newly completed move.
REQ-008 color  output  1  assigned side: 0 = white, 1 = black.
REQ-009 color_valid  output  1  one-cycle pulse; color has just been updated.
REQ-010 parse_err  output  1  one-cycle pulse on detection of a malformed line.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states: IDLE, COLOR, COLOR_END, ROW, TILE_OR_ROW, TERM, ERR; the FSM advances only on cycles with rx_valid=1.
REQ-013 IDLE: '-' goes to COLOR; '@'..'Z' sets col = byte - 0x40 and goes to ROW; CR or LF is ignored; any other byte goes to ERR.
REQ-014 COLOR: 'W' sets pending colour 0, 'B' sets pending colour 1, then goes to COLOR_END; any other byte goes to ERR.
REQ-015 COLOR_END: CR is ignored; LF updates color from the pending colour, pulses color_valid and goes to IDLE; any other byte goes to ERR.
REQ-016 ROW: the first byte must be '0'..'9', which sets row = digit, digit count = 1 and goes to TILE_OR_ROW; any other byte goes to ERR.
REQ-017 TILE_OR_ROW, digit byte: row = row*10 + digit, using 14-bit intermediate arithmetic.
REQ-018 TILE_OR_ROW, overflow: if the digit count would exceed ROW_DIGITS_MAX, or the result exceeds 1023, go to ERR.
REQ-019 TILE_OR_ROW, tile byte: '+', '/' or '\' (0x5C) latches the tile code and goes to TERM; any other byte goes to ERR.
REQ-020 TERM: CR is ignored; LF loads move_out and pulses move_valid, then goes to IDLE; any other byte goes to ERR.
REQ-021 Latency: move_valid, color_valid and parse_err each rise on the clock edge that consumes the triggering byte and stay high for exactly one cycle.
REQ-022 move_out and color retain their values until the next successful load.
REQ-023 ERR is entered with a parse_err pulse, then discards bytes until LF, which returns it to IDLE.
REQ-024 A '-' received while in ERR does not restart parsing; only LF exits ERR.
REQ-025 Partial-line fields (col, row, tile, pending colour) never reach the outputs unless their line completes correctly.
REQ-026 With rx_valid held high continuously, every byte is consumed with no stall and no dropped byte.
REQ-027 Back-to-back lines are accepted; a move_valid pulse is followed by the next line's first byte on the very next cycle.
REQ-028 rx_valid=0 cycles leave all state unchanged; there is no timeout.

Reset
REQ-029 Reset asynchronously forces: state=IDLE, move_out=0, move_valid=0, color=0, color_valid=0, parse_err=0, busy=0, and all partial fields cleared.
REQ-030 Reset asserted mid-line discards the partial line; the first byte after reset release is parsed from IDLE.

Structure
REQ-031 Package trax_pkg holds the tile codes (plus, slash, bslash), MOVE_W=22, the ASCII constants (CR, LF, '@', '-', 'W', 'B', '+', '/', '\') and the FSM state enumeration.
REQ-032 Sub-module trax_char_class is a combinational byte classifier.
REQ-033 trax_char_class outputs: is_digit, digit value, is_col_letter, column value, is_tile, tile code, is_cr, is_lf.
REQ-034 trax_move_decoder is instantiated between the UART receiver and the game controller; move_valid drives the controller's end-of-receive input.

Verification
REQ-035 Bytes "-B\n" -> color=1 and a color_valid pulse one cycle after the LF; move_valid stays 0.
REQ-036 Bytes "A2/\r\n" back-to-back -> move_out = {10, 10'd1, 10'd2} with a single move_valid pulse; busy=0 afterwards.
REQ-037 Bytes "@0+\n" then immediately "C12\\\n" -> move_out = {01,0,0}, then {11,10'd3,10'd12}, giving two move_valid pulses.
REQ-038 Bytes "B1x\n" then "-W\n" -> parse_err pulse on 'x', no move_valid, then color=0 with a color_valid pulse.
REQ-039 Bytes "A1024+\n" -> parse_err on the final '4' digit; "A1023+\n" -> row=1023 accepted.
REQ-040 Bytes "D3", then reset pulsed, then "A1+\n" -> only the move {01,1,1} is reported; all outputs are 0 during reset.

Source files
------------

// File: rtl/trax_pkg.sv
// trax_pkg: shared tile codes, move width, ASCII constants and decoder FSM states
package trax_pkg;
  localparam int MOVE_W = 22;
  typedef enum logic [1:0] {TILE_NONE = 2'd0, TILE_PLUS = 2'd1, TILE_SLASH = 2'd2, TILE_BSLASH = 2'd3} tile_e;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_AT = 8'h40;
  localparam logic [7:0] CH_DASH = 8'h2d;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_PLUS = 8'h2b;
  localparam logic [7:0] CH_SLASH = 8'h2f;
  localparam logic [7:0] CH_BSLASH = 8'h5c;
  typedef enum logic [2:0] {IDLE, COLOR, COLOR_END, ROW, TILE_OR_ROW, TERM, ERR} state_e;
endpackage

// File: rtl/trax_move_decoder_if.sv
// trax_move_decoder_if: UART byte stream in (rx_data/rx_valid); move_out/move_valid, color/color_valid, parse_err, busy out
interface trax_move_decoder_if;
  import trax_pkg::*;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [MOVE_W-1:0] move_out;
  logic move_valid;
  logic color;
  logic color_valid;
  logic parse_err;
  logic busy;
  modport master (output rx_data, rx_valid, input move_out, move_valid, color, color_valid, parse_err, busy);
  modport slave (input rx_data, rx_valid, output move_out, move_valid, color, color_valid, parse_err, busy);
endinterface

// File: rtl/trax_char_class.sv
// trax_char_class: combinational byte classifier (in: byte_i; out: digit, column letter, tile, CR, LF flags and values)
module trax_char_class
  import trax_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o,
  output logic       is_col_letter_o,
  output logic [9:0] col_o,
  output logic       is_tile_o,
  output tile_e      tile_o,
  output logic       is_cr_o,
  output logic       is_lf_o
);
  always_comb begin
    is_digit_o = byte_i >= 8'h30 && byte_i <= 8'h39;
    digit_o = byte_i[3:0];
    is_col_letter_o = byte_i >= CH_AT && byte_i <= CH_AT + 8'd26;
    col_o = {5'd0, byte_i[4:0]};
    tile_o = byte_i == CH_PLUS ? TILE_PLUS : byte_i == CH_SLASH ? TILE_SLASH : byte_i == CH_BSLASH ? TILE_BSLASH : TILE_NONE;
    is_tile_o = tile_o != TILE_NONE;
    is_cr_o = byte_i == CH_CR;
    is_lf_o = byte_i == CH_LF;
  end
endmodule

// File: rtl/trax_move_decoder.sv
// trax_move_decoder: parses Trax ASCII lines (clk, async reset, bus slave) into moves and colour assignments
module trax_move_decoder
  import trax_pkg::*;
#(
  parameter int ROW_DIGITS_MAX = 4
) (
  input logic clk,
  input logic reset,
  trax_move_decoder_if.slave bus
);
  localparam logic [7:0] DMAX = 8'(ROW_DIGITS_MAX);
  state_e state_q, state_d;
  logic [9:0] col_q, col_d, row_q, row_d;
  tile_e tile_q, tile_d;
  logic pcol_q, pcol_d;
  logic [7:0] cnt_q, cnt_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic mv_q, mv_d, color_q, color_d, cv_q, cv_d, err_q, err_d;
  logic c_digit, c_col, c_tile, c_cr, c_lf;
  logic [3:0] c_dval;
  logic [9:0] c_cval;
  tile_e c_tcode;
  logic [13:0] row_ext;
  trax_char_class u_cls (
    .byte_i(bus.rx_data), .is_digit_o(c_digit), .digit_o(c_dval), .is_col_letter_o(c_col), .col_o(c_cval),
    .is_tile_o(c_tile), .tile_o(c_tcode), .is_cr_o(c_cr), .is_lf_o(c_lf)
  );
  assign row_ext = 14'(row_q) * 14'd10 + 14'(c_dval);
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    tile_d = tile_q;
    pcol_d = pcol_q;
    cnt_d = cnt_q;
    move_d = move_q;
    mv_d = 1'b0;
    color_d = color_q;
    cv_d = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == CH_DASH) state_d = COLOR;
          else if (c_col) begin
            col_d = c_cval;
            state_d = ROW;
          end else if (!(c_cr || c_lf)) state_d = ERR;
        end
        COLOR: begin
          pcol_d = bus.rx_data == CH_B;
          state_d = (bus.rx_data == CH_W || bus.rx_data == CH_B) ? COLOR_END : ERR;
        end
        COLOR_END: begin
          if (c_lf) begin
            color_d = pcol_q;
            cv_d = 1'b1;
            state_d = IDLE;
          end else if (!c_cr) state_d = ERR;
        end
        ROW: begin
          row_d = {6'd0, c_dval};
          cnt_d = 8'd1;
          state_d = c_digit ? TILE_OR_ROW : ERR;
        end
        TILE_OR_ROW: begin
          if (c_digit) begin
            if (cnt_q >= DMAX || row_ext > 14'd1023) state_d = ERR;
            else begin
              row_d = row_ext[9:0];
              cnt_d = cnt_q + 8'd1;
            end
          end else if (c_tile) begin
            tile_d = c_tcode;
            state_d = TERM;
          end else state_d = ERR;
        end
        TERM: begin
          if (c_lf) begin
            move_d = {tile_q, col_q, row_q};
            mv_d = 1'b1;
            state_d = IDLE;
          end else if (!c_cr) state_d = ERR;
        end
        ERR: state_d = c_lf ? IDLE : ERR;
        default: state_d = IDLE;
      endcase
    end
    // parse_err pulses only on the byte that enters ERR, not while discarding
    err_d = bus.rx_valid && state_d == ERR && state_q != ERR;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      tile_q <= TILE_NONE;
      pcol_q <= 1'b0;
      cnt_q <= '0;
      move_q <= '0;
      mv_q <= 1'b0;
      color_q <= 1'b0;
      cv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      tile_q <= tile_d;
      pcol_q <= pcol_d;
      cnt_q <= cnt_d;
      move_q <= move_d;
      mv_q <= mv_d;
      color_q <= color_d;
      cv_q <= cv_d;
      err_q <= err_d;
    end
  end
  assign bus.move_out = move_q;
  assign bus.move_valid = mv_q;
  assign bus.color = color_q;
  assign bus.color_valid = cv_q;
  assign bus.parse_err = err_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_trax_move_decoder.sv
// tb_trax_move_decoder: directed byte streams with hand-computed moves, colours and error pulses
module tb_trax_move_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int mv_cnt = 0;
  int cv_cnt = 0;
  int err_cnt = 0;
  trax_move_decoder_if bus ();
  trax_move_decoder #(.ROW_DIGITS_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tally();
    mv_cnt += int'(bus.move_valid);
    cv_cnt += int'(bus.color_valid);
    err_cnt += int'(bus.parse_err);
  endtask

  task automatic clr();
    mv_cnt = 0;
    cv_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    tally();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tally();
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_move_out", 32'(bus.move_out), 32'h0);
    chk("rst_pulses", {29'd0, bus.move_valid, bus.color_valid, bus.parse_err}, 32'h0);
    chk("rst_color_busy", {30'd0, bus.color, bus.busy}, 32'h0);
    reset = 1'b0;
    idle(1);

    clr();
    send("-");
    chk("color_busy", 32'(bus.busy), 32'h1);
    send("B");
    send(8'h0a);
    chk("colorB_valid", 32'(bus.color_valid), 32'h1);
    chk("colorB", 32'(bus.color), 32'h1);
    idle(1);
    chk("colorB_pulse_end", 32'(bus.color_valid), 32'h0);
    chk("colorB_no_move", 32'(mv_cnt), 32'h0);

    clr();
    send_str("A2/\r\n");
    chk("A2_valid", 32'(bus.move_valid), 32'h1);
    chk("A2_move", 32'(bus.move_out), 32'({2'b10, 10'd1, 10'd2}));
    idle(1);
    chk("A2_pulse_end", 32'(bus.move_valid), 32'h0);
    chk("A2_busy", 32'(bus.busy), 32'h0);
    chk("A2_count", 32'(mv_cnt), 32'h1);

    clr();
    send_str("@0+\n");
    chk("at0_move", 32'(bus.move_out), 32'({2'b01, 10'd0, 10'd0}));
    send_str("C12\\\n");
    chk("C12_move", 32'(bus.move_out), 32'({2'b11, 10'd3, 10'd12}));
    chk("C12_valid", 32'(bus.move_valid), 32'h1);
    idle(1);
    chk("b2b_count", 32'(mv_cnt), 32'h2);

    clr();
    send_str("B1");
    send("x");
    chk("x_err", 32'(bus.parse_err), 32'h1);
    send(8'h0a);
    chk("x_err_pulse_end", 32'(bus.parse_err), 32'h0);
    chk("x_busy", 32'(bus.busy), 32'h0);
    send_str("-W\n");
    chk("colorW_valid", 32'(bus.color_valid), 32'h1);
    chk("colorW", 32'(bus.color), 32'h0);
    chk("x_counts", {mv_cnt[15:0], err_cnt[15:0]}, {16'd0, 16'd1});
    chk("move_retained", 32'(bus.move_out), 32'({2'b11, 10'd3, 10'd12}));

    clr();
    send_str("A102");
    chk("A102_no_err", 32'(err_cnt), 32'h0);
    send("4");
    chk("A1024_err", 32'(bus.parse_err), 32'h1);
    send_str("+\n");
    chk("A1024_no_move", 32'(mv_cnt), 32'h0);
    send_str("A1023+\n");
    chk("A1023_move", 32'(bus.move_out), 32'({2'b01, 10'd1, 10'd1023}));
    chk("A1023_valid", 32'(bus.move_valid), 32'h1);

    clr();
    send_str("A0000");
    chk("digits4_no_err", 32'(err_cnt), 32'h0);
    send("5");
    chk("digits5_err", 32'(bus.parse_err), 32'h1);
    send_str("+\n");
    chk("digits5_no_move", 32'(mv_cnt), 32'h0);

    clr();
    send_str("x-W\n");
    chk("err_dash_no_color", 32'(cv_cnt), 32'h0);
    chk("err_dash_color_kept", 32'(bus.color), 32'h0);
    send_str("-B\n");
    chk("after_err_color", 32'(bus.color), 32'h1);

    clr();
    send("B");
    idle(3);
    chk("gap_busy", 32'(bus.busy), 32'h1);
    send_str("5+\n");
    chk("gap_move", 32'(bus.move_out), 32'({2'b01, 10'd2, 10'd5}));

    clr();
    send_str("D3");
    bus.rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_move", 32'(bus.move_out), 32'h0);
    chk("rst_async_misc", {28'd0, bus.color, bus.busy, bus.move_valid, bus.parse_err}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    send_str("A1+\n");
    chk("post_rst_move", 32'(bus.move_out), 32'({2'b01, 10'd1, 10'd1}));
    idle(1);
    chk("post_rst_counts", {mv_cnt[15:0], err_cnt[15:0]}, {16'd1, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
